// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard/control logic: FSM states, register
// and ALU-op constants, and the bundled stall/flush control word.
package pipeline_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hcu_state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam logic [3:0] NOP_ALUOP = 4'd8;
    localparam int         CNT_W     = 4;

    typedef struct packed {
        logic pc_wre;
        logic if_id_wre;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } hcu_ctrl_t;

    // Field order: {pc_wre, if_id_wre, if_id_flush, id_ex_flush, ex_mem_flush}
    localparam hcu_ctrl_t CTRL_RESET  = hcu_ctrl_t'(5'b00111);
    localparam hcu_ctrl_t CTRL_RUN    = hcu_ctrl_t'(5'b11000);
    localparam hcu_ctrl_t CTRL_BUBBLE = hcu_ctrl_t'(5'b00010);
    localparam hcu_ctrl_t CTRL_BRANCH = hcu_ctrl_t'(5'b11111);
    localparam hcu_ctrl_t CTRL_JUMP   = hcu_ctrl_t'(5'b11100);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the ID sources and the EX load
// destination; shared with the forwarding unit.
module load_use_detect
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ID_rs,
    input  logic [REG_ADDR_W-1:0] ID_rt,
    input  logic                  ID_UsesRs,
    input  logic                  ID_UsesRt,
    input  logic                  EX_MemRead,
    input  logic                  EX_RegWre,
    input  logic [REG_ADDR_W-1:0] EX_WriteReg,
    output logic                  hazard
);

    logic ex_writes_live;
    logic rs_match;
    logic rt_match;

    // $zero is never a real producer, so a load "into" it cannot create a hazard.
    assign ex_writes_live = EX_MemRead & EX_RegWre &
                            (EX_WriteReg != REG_ADDR_W'(REG_ZERO));
    assign rs_match       = ID_UsesRs & (ID_rs == EX_WriteReg);
    assign rt_match       = ID_UsesRt & (ID_rt == EX_WriteReg);
    assign hazard         = ex_writes_live & (rs_match | rt_match);

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush control for the pipeline registers: load-use stall FSM, branch and
// jump redirects. Define HAZARD_PERF_EN to build the stall/flush event counters.
module hazard_control_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] ID_rs,
    input  logic [REG_ADDR_W-1:0] ID_rt,
    input  logic                  ID_UsesRs,
    input  logic                  ID_UsesRt,
    input  logic                  ID_Jump,
    input  logic                  EX_MemRead,
    input  logic                  EX_RegWre,
    input  logic [REG_ADDR_W-1:0] EX_WriteReg,
    input  logic                  MEM_BranchTaken,
    output logic                  PCWre,
    output logic                  IF_ID_Wre,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Flush,
    output logic                  EX_MEM_Flush,
    output logic [31:0]           StallCount,
    output logic [31:0]           FlushCount
);

    generate
        if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 15) begin : g_bad_cfg
            $error("hazard_control_unit: LOAD_USE_STALLS must be in 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_USE_STALLS - 1);
    localparam bit               MULTI_STALL = (LOAD_USE_STALLS > 1);

    hcu_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             hazard;
    hcu_ctrl_t        ctrl;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
        .ID_rs       (ID_rs),
        .ID_rt       (ID_rt),
        .ID_UsesRs   (ID_UsesRs),
        .ID_UsesRt   (ID_UsesRt),
        .EX_MemRead  (EX_MemRead),
        .EX_RegWre   (EX_RegWre),
        .EX_WriteReg (EX_WriteReg),
        .hazard      (hazard)
    );

    // Branch beats stall beats jump; a jump seen during STALL is simply dropped
    // and re-presented by ID once it advances.
    always_comb begin
        ctrl    = CTRL_RUN;
        state_n = state;
        cnt_n   = cnt;
        if (!Reset) begin
            ctrl    = CTRL_RESET;
            state_n = RUN;
            cnt_n   = '0;
        end else if (MEM_BranchTaken) begin
            ctrl    = CTRL_BRANCH;
            state_n = RUN;
            cnt_n   = '0;
        end else if (state == STALL) begin
            ctrl = CTRL_BUBBLE;
            if (cnt == CNT_W'(1)) begin
                state_n = RUN;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt - CNT_W'(1);
            end
        end else if (hazard) begin
            ctrl = CTRL_BUBBLE;
            if (MULTI_STALL) begin
                state_n = STALL;
                cnt_n   = STALL_INIT;
            end
        end else if (ID_Jump) begin
            ctrl = CTRL_JUMP;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    assign PCWre        = ctrl.pc_wre;
    assign IF_ID_Wre    = ctrl.if_id_wre;
    assign IF_ID_Flush  = ctrl.if_id_flush;
    assign ID_EX_Flush  = ctrl.id_ex_flush;
    assign EX_MEM_Flush = ctrl.ex_mem_flush;

`ifdef HAZARD_PERF_EN
    logic stall_evt;
    logic redirect_evt;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // With Reset high, ID_EX_Flush comes only from a bubble or a branch, and
    // IF_ID_Flush only from a branch or an honoured jump.
    assign stall_evt    = ctrl.id_ex_flush & ~MEM_BranchTaken;
    assign redirect_evt = ctrl.if_id_flush;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt)    stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect_evt) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench: two instances (1-cycle and 3-cycle load-use stall) share inputs.
module tb_hazard_control_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] ID_rs, ID_rt, EX_WriteReg;
    logic       ID_UsesRs, ID_UsesRt, ID_Jump, EX_MemRead, EX_RegWre, MEM_BranchTaken;

    logic        a_pc, a_ifw, a_iff, a_idf, a_exf;
    logic        b_pc, b_ifw, b_iff, b_idf, b_exf;
    logic [31:0] a_sc, a_fc, b_sc, b_fc;

    int n_vec = 0;
    int n_bad = 0;

    // {PCWre, IF_ID_Wre, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
    localparam logic [4:0] RST = 5'b00111;
    localparam logic [4:0] DEF = 5'b11000;
    localparam logic [4:0] BUB = 5'b00010;
    localparam logic [4:0] BR  = 5'b11111;
    localparam logic [4:0] JMP = 5'b11100;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 Clk = ~Clk;

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
        .EX_MemRead(EX_MemRead), .EX_RegWre(EX_RegWre), .EX_WriteReg(EX_WriteReg),
        .MEM_BranchTaken(MEM_BranchTaken),
        .PCWre(a_pc), .IF_ID_Wre(a_ifw), .IF_ID_Flush(a_iff), .ID_EX_Flush(a_idf),
        .EX_MEM_Flush(a_exf), .StallCount(a_sc), .FlushCount(a_fc)
    );

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
        .EX_MemRead(EX_MemRead), .EX_RegWre(EX_RegWre), .EX_WriteReg(EX_WriteReg),
        .MEM_BranchTaken(MEM_BranchTaken),
        .PCWre(b_pc), .IF_ID_Wre(b_ifw), .IF_ID_Flush(b_iff), .ID_EX_Flush(b_idf),
        .EX_MEM_Flush(b_exf), .StallCount(b_sc), .FlushCount(b_fc)
    );

    wire [4:0] c1 = {a_pc, a_ifw, a_iff, a_idf, a_exf};
    wire [4:0] c3 = {b_pc, b_ifw, b_iff, b_idf, b_exf};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic jmp,
                          input logic mr, input logic rw, input logic [4:0] wr,
                          input logic br);
        ID_rs = rs; ID_rt = rt; ID_UsesRs = urs; ID_UsesRt = urt; ID_Jump = jmp;
        EX_MemRead = mr; EX_RegWre = rw; EX_WriteReg = wr; MEM_BranchTaken = br;
        #1;
    endtask

    // lw $3 in EX, add $4,$3,$5 in ID
    task automatic idle();     set_in(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0); endtask
    task automatic load_use(); set_in(5'd3, 5'd5, 1, 1, 0, 1, 1, 5'd3, 0); endtask
    task automatic branch();   set_in(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1); endtask
    task automatic jump();     set_in(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0); endtask
    task automatic tick();     @(posedge Clk); #1; endtask

    initial begin
        Reset = 1'b0;
        idle();
        chk("rst_ctl1", 32'(c1), 32'(RST));
        chk("rst_ctl3", 32'(c3), 32'(RST));
        chk("rst_sc",   a_sc, 32'd0);
        chk("rst_fc",   a_fc, 32'd0);
        tick();
        Reset = 1'b1;
        idle();
        chk("idle1", 32'(c1), 32'(DEF));
        chk("idle3", 32'(c3), 32'(DEF));

        // load-use: 1 bubble vs 3 bubbles
        load_use();
        chk("lu_c1_1", 32'(c1), 32'(BUB));
        chk("lu_c3_1", 32'(c3), 32'(BUB));
        tick(); idle();
        chk("lu_c1_2", 32'(c1), 32'(DEF));
        chk("lu_c3_2", 32'(c3), 32'(BUB));
        tick();
        chk("lu_c3_3", 32'(c3), 32'(BUB));
        tick();
        chk("lu_c3_4", 32'(c3), 32'(DEF));
        chk("lu_c1_4", 32'(c1), 32'(DEF));

        // $zero destination, and a match on an unused source
        set_in(5'd0, 5'd9, 1, 1, 0, 1, 1, 5'd0, 0);
        chk("zero1", 32'(c1), 32'(DEF));
        chk("zero3", 32'(c3), 32'(DEF));
        set_in(5'd3, 5'd5, 0, 1, 0, 1, 1, 5'd3, 0);
        chk("nouse3", 32'(c3), 32'(DEF));
        tick();
        chk("nouse3_nxt", 32'(c3), 32'(DEF));

        // load-use and branch together
        set_in(5'd3, 5'd5, 1, 1, 0, 1, 1, 5'd3, 1);
        chk("lubr1", 32'(c1), 32'(BR));
        chk("lubr3", 32'(c3), 32'(BR));
        tick(); idle();
        chk("lubr3_nxt", 32'(c3), 32'(DEF));

        // branch in 2nd cycle of a 3-cycle stall
        load_use();
        chk("sbr3_1", 32'(c3), 32'(BUB));
        tick(); branch();
        chk("sbr3_2", 32'(c3), 32'(BR));
        tick(); idle();
        chk("sbr3_3", 32'(c3), 32'(DEF));

        // jump
        jump();
        chk("jmp1", 32'(c1), 32'(JMP));
        chk("jmp3", 32'(c3), 32'(JMP));
        tick(); idle();
        chk("jmp3_nxt", 32'(c3), 32'(DEF));

        // jump presented during stall is not honoured
        load_use();
        tick(); jump();
        chk("sjmp3", 32'(c3), 32'(BUB));
        chk("sjmp1", 32'(c1), 32'(JMP));
        tick(); idle();
        chk("sjmp3_2", 32'(c3), 32'(BUB));
        tick();
        chk("sjmp3_3", 32'(c3), 32'(DEF));

        // reset mid-stall
        load_use();
        tick(); idle();
        chk("rms_pre", 32'(c3), 32'(BUB));
        #2 Reset = 1'b0; #1;
        chk("rms_ctl", 32'(c3), 32'(RST));
        chk("rms_sc",  b_sc, 32'd0);
        tick();
        Reset = 1'b1; #1;
        chk("rms_rel", 32'(c3), 32'(DEF));
        tick();
        chk("rms_nobub", 32'(c3), 32'(DEF));

        // counters: 2 hazards (second via rt) + 1 branch
        load_use();
        tick(); idle(); tick(); tick(); tick();
        set_in(5'd7, 5'd3, 1, 1, 0, 1, 1, 5'd3, 0);
        chk("rt_haz1", 32'(c1), 32'(BUB));
        tick(); idle(); tick(); tick(); tick();
        branch();
        tick(); idle();
        chk("perf_sc1", a_sc, PERF ? 32'd2 : 32'd0);
        chk("perf_fc1", a_fc, PERF ? 32'd1 : 32'd0);
        chk("perf_sc3", b_sc, PERF ? 32'd6 : 32'd0);
        chk("perf_fc3", b_fc, PERF ? 32'd1 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
